logic_gate_bist: RTL

Parametrised built-in self-test engine for combinational logic gates. It sweeps all 2^N_IN input combinations into an attached N-input gate, waits a programmable settle time per vector, and samples the gate output. Each sample is compared against the expected value for the selected gate function, and the engine reports pass/fail, the mismatch count and the first failing vector. It sits beside gate-level blocks in the logic-gate library and replaces per-gate hand-written stimulus sequences with one reusable, synthesizable checker.

---
 rtl/logic_gate_bist.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/logic_gate_bist.sv
// logic_gate_bist: exhaustive self-test sweep for an N_IN-input logic gate.
// Drives every input vector in order, holds each for SETTLE cycles, samples
// the gate output on the following CHECK cycle and compares it against the
// selected reference function. Results are published when the sweep ends.
module logic_gate_bist #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            dut_y,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            mode_err,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, FINISH} state_t;

    state_t          state;
    state_t          next_state;

    logic [2:0]      mode_q;
    logic [2:0]      mode_q_next;
    logic            mode_bad;
    logic            mode_bad_next;
    logic [N_IN-1:0] vec;
    logic [N_IN-1:0] vec_next;
    logic [7:0]      settle_cnt;
    logic [N_IN:0]   work_cnt;
    logic [N_IN:0]   work_cnt_next;
    logic [N_IN-1:0] cap_vec;
    logic [N_IN-1:0] cap_vec_next;
    logic            cap_valid;
    logic            cap_valid_next;

    logic            mode_legal;
    logic            last_vec;
    logic            settle_done;
    logic            mismatch;

    logic            busy_next;
    logic            done_next;
    logic [N_IN-1:0] dut_in_next;

    // Reference output of the selected gate function for input vector v.
    // Reduction operators cover N_IN=1 naturally (they reduce to the bit).
    function automatic logic gate_ref(input logic [2:0] m, input logic [N_IN-1:0] v);
        case (m)
            3'd0:    return &v;
            3'd1:    return |v;
            3'd2:    return ~&v;
            3'd3:    return ~|v;
            3'd4:    return ^v;
            3'd5:    return ~^v;
            default: return 1'b0;
        endcase
    endfunction

    assign mode_legal  = (mode <= 3'd5);
    assign last_vec    = (vec == {N_IN{1'b1}});
    assign settle_done = (settle_cnt == 8'(SETTLE - 1));
    assign mismatch    = (dut_y != gate_ref(mode_q, vec));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic: settle window, per-vector check, sweep completion.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = mode_legal ? APPLY : FINISH;
            APPLY:   if (settle_done) next_state = CHECK;
            CHECK:   next_state = last_vec ? FINISH : APPLY;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode, computed one cycle early so every output is a flop.
    always_comb begin
        busy_next   = (next_state == APPLY) || (next_state == CHECK);
        done_next   = (next_state == FINISH);
        dut_in_next = busy_next ? vec_next : '0;
    end

    // Working-state updates: latch on start, count and capture on mismatch.
    always_comb begin
        mode_q_next    = mode_q;
        mode_bad_next  = mode_bad;
        vec_next       = vec;
        work_cnt_next  = work_cnt;
        cap_vec_next   = cap_vec;
        cap_valid_next = cap_valid;
        if (state == IDLE && start) begin
            mode_q_next    = mode;
            mode_bad_next  = !mode_legal;
            vec_next       = '0;
            work_cnt_next  = '0;
            cap_vec_next   = '0;
            cap_valid_next = 1'b0;
        end
        if (state == CHECK) begin
            if (mismatch) begin
                work_cnt_next = work_cnt + (N_IN+1)'(1);
                if (!cap_valid) begin
                    cap_vec_next   = vec;
                    cap_valid_next = 1'b1;
                end
            end
            if (!last_vec) vec_next = vec + N_IN'(1);
        end
    end

    // Working registers and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= '0;
            mode_bad   <= 1'b0;
            vec        <= '0;
            settle_cnt <= '0;
            work_cnt   <= '0;
            cap_vec    <= '0;
            cap_valid  <= 1'b0;
        end else begin
            mode_q     <= mode_q_next;
            mode_bad   <= mode_bad_next;
            vec        <= vec_next;
            settle_cnt <= (state == APPLY) ? settle_cnt + 8'd1 : 8'd0;
            work_cnt   <= work_cnt_next;
            cap_vec    <= cap_vec_next;
            cap_valid  <= cap_valid_next;
        end
    end

    // Registered outputs; results load on the edge entering FINISH so they
    // are already valid during the done cycle, including the last check.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mode_err         <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            dut_in <= dut_in_next;
            busy   <= busy_next;
            done   <= done_next;
            if (next_state == FINISH) begin
                err_count        <= mode_bad_next ? '0 : work_cnt_next;
                pass             <= (work_cnt_next == '0) && !mode_bad_next;
                mode_err         <= mode_bad_next;
                first_fail_vec   <= cap_vec_next;
                first_fail_valid <= cap_valid_next && !mode_bad_next;
            end
        end
    end

endmodule
